// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the interrupt pending controller.
//   irq_state_e : handshake FSM states (IDLE, PRESENT, HOLDOFF)
//   N_SRC_DEF   : default number of request sources
//   ID_W_DEF    : default request-ID width ($clog2(N_SRC_DEF))
//   MASK_RST    : per-source mask value after reset (1 = blocked)
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int N_SRC_DEF = 4;
    localparam int ID_W_DEF  = 2;

    // Every source comes out of reset blocked; the top replicates this bit.
    localparam logic MASK_RST = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl_if
// Mask-register access and valid/ack request handshake between the pending
// controller (slave) and its consumer / software side (master).
//   mask_we   : mask write strobe              (master -> slave)
//   mask_din  : mask write data, 1 = blocked   (master -> slave)
//   mask_q    : current mask register          (slave -> master)
//   irq_valid : request presented              (slave -> master)
//   irq_id    : presented request ID           (slave -> master)
//   irq_ack   : consumer accepts irq_id        (master -> slave)
// ---------------------------------------------------------------------------
interface irq_pending_ctrl_if
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
);
    logic             mask_we;
    logic [N_SRC-1:0] mask_din;
    logic [N_SRC-1:0] mask_q;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_id;
    logic             irq_ack;

    modport master (
        output mask_we, mask_din, irq_ack,
        input  mask_q, irq_valid, irq_id
    );

    modport slave (
        input  mask_we, mask_din, irq_ack,
        output mask_q, irq_valid, irq_id
    );
endinterface

// File: rtl/irq_edge_detect.sv
// ---------------------------------------------------------------------------
// irq_edge_detect
// Per-source rising-edge detector for the raw request lines.
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   irq_in : raw request levels
//   rise   : one-cycle pulse per source on a 0->1 transition
// Build option IRQ_SYNC_EN: inserts a 2-flop synchronizer (reset to 0) in
// front of the edge detector, adding two cycles of capture latency.
// The history flops reset to 0, so a line already high when reset is
// released produces exactly one rising edge.
// ---------------------------------------------------------------------------
module irq_edge_detect #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    output logic [N_SRC-1:0] rise
);
    logic [N_SRC-1:0] irq_s;
    logic [N_SRC-1:0] hist_reg;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1_reg;
    logic [N_SRC-1:0] sync2_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= irq_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign irq_s = sync2_reg;
`else
    assign irq_s = irq_in;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_reg <= '0;
        end else begin
            hist_reg <= irq_s;
        end
    end

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rise
        assign rise[gi] = irq_s[gi] & ~hist_reg[gi];
    end
endmodule

// File: rtl/irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// irq_pending_ctrl
// Front end of the priority encoder: captures request edges into sticky
// pending bits, applies a software mask, drives the registered masked
// pending vector to the encoder, and presents one highest-priority request
// at a time over a valid/ack handshake.
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   irq_in   : raw request lines (edge detected internally)
//   pend_vec : registered pending & ~mask, encoder input
//   bus      : mask access and valid/ack handshake (slave modport)
// Build option IRQ_SYNC_EN: request lines are synchronized before edge
// detection (see irq_edge_detect); handshake behaviour is unchanged.
// ---------------------------------------------------------------------------
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   irq_in,
    output logic [N_SRC-1:0]   pend_vec,
    irq_pending_ctrl_if.slave  bus
);
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_reg;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] mask_reg;
    logic [N_SRC-1:0] pend_vec_reg;
    irq_state_e       state_reg;
    logic             valid_reg;
    logic [ID_W-1:0]  id_reg;
    logic [ID_W-1:0]  sel_id;
    logic             sel_any;

    irq_edge_detect #(.N_SRC(N_SRC)) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_in (irq_in),
        .rise   (rise)
    );

    // The clear targets the frozen presented ID. A new edge in the same
    // cycle re-sets the bit, so the request is not lost.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
        assign clr[gi]          = (state_reg == PRESENT) && bus.irq_ack &&
                                  (id_reg == ID_W'(gi));
        assign pending_next[gi] = (pending_reg[gi] & ~clr[gi]) | rise[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_reg  <= '0;
            mask_reg     <= {N_SRC{MASK_RST}};
            pend_vec_reg <= '0;
        end else begin
            pending_reg  <= pending_next;
            pend_vec_reg <= pending_reg & ~mask_reg;
            if (bus.mask_we) begin
                mask_reg <= bus.mask_din;
            end
        end
    end

    // Highest set index wins; ascending scan lets later hits override.
    always_comb begin
        sel_id  = '0;
        sel_any = |pend_vec_reg;
        for (int i = 0; i < N_SRC; i++) begin
            if (pend_vec_reg[i]) begin
                sel_id = ID_W'(i);
            end
        end
    end

    // HOLDOFF gives pend_vec one edge to drop the acknowledged bit before
    // IDLE evaluates it again.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            id_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_any) begin
                        id_reg    <= sel_id;
                        valid_reg <= 1'b1;
                        state_reg <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.irq_ack) begin
                        valid_reg <= 1'b0;
                        state_reg <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    state_reg <= IDLE;
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pend_vec      = pend_vec_reg;
    assign bus.mask_q    = mask_reg;
    assign bus.irq_valid = valid_reg;
    assign bus.irq_id    = id_reg;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_pending_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the pending controller.
// ---------------------------------------------------------------------------
module tb_irq_pending_ctrl;

`ifdef IRQ_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] pend_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_pending_ctrl_if #(.N_SRC(4), .ID_W(2)) bus ();

    irq_pending_ctrl #(.N_SRC(4), .ID_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .pend_vec (pend_vec),
        .bus      (bus)
    );

    // ---------------- behavioural model ----------------
    // Phase: 0 = waiting for work, 1 = request shown, 2 = one-cycle gap.
    int m_pend, m_mask, m_pv, m_hist, m_s1, m_s2, m_phase, m_valid, m_id;

    function automatic int highest(input int v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_step(input int irq, input int mwe, input int mdin,
                              input int ack, input int rstn);
        int seen, rise, new_pend, new_pv;
        if (rstn == 0) begin
            m_pend = 0; m_mask = 15; m_pv = 0; m_hist = 0;
            m_s1 = 0; m_s2 = 0; m_phase = 0; m_valid = 0; m_id = 0;
        end else begin
            if (SYNC) begin
                seen = m_s2;
                m_s2 = m_s1;
                m_s1 = irq;
            end else begin
                seen = irq;
            end
            rise     = seen & ~m_hist & 15;
            m_hist   = seen;
            new_pv   = m_pend & ~m_mask & 15;
            new_pend = m_pend;
            if (m_phase == 1 && ack != 0) new_pend = new_pend & ~(1 << m_id);
            new_pend = new_pend | rise;
            if (mwe != 0) m_mask = mdin & 15;
            case (m_phase)
                0: if (m_pv != 0) begin
                       m_id = highest(m_pv); m_valid = 1; m_phase = 1;
                   end
                1: if (ack != 0) begin
                       m_valid = 0; m_phase = 2;
                   end
                default: m_phase = 0;
            endcase
            m_pend = new_pend;
            m_pv   = new_pv;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        chk("pend_vec", 32'(pend_vec), 32'(m_pv));
        chk("irq_valid", 32'(bus.irq_valid), 32'(m_valid));
        chk("irq_id", 32'(bus.irq_id), 32'(m_id));
        chk("mask_q", 32'(bus.mask_q), 32'(m_mask));
    endtask

    task automatic step(input logic [3:0] irq, input logic mwe, input logic [3:0] mdin,
                        input logic ack, input logic rstn);
        irq_in       = irq;
        bus.mask_we  = mwe;
        bus.mask_din = mdin;
        bus.irq_ack  = ack;
        rst_n        = rstn;
        @(posedge clk);
        model_step(int'(irq), int'(mwe), int'(mdin), int'(ack), int'(rstn));
        #1;
        compare_model();
    endtask

    // Holds irq steady with no ack until a request is shown (bounded).
    task automatic wait_valid(input logic [3:0] irq);
        for (int n = 0; n < 10 && bus.irq_valid !== 1'b1; n++) begin
            step(irq, 1'b0, 4'h0, 1'b0, 1'b1);
        end
        chk("wait_valid", 32'(bus.irq_valid), 32'd1);
    endtask

    initial begin
        irq_in = '0; bus.mask_we = 1'b0; bus.mask_din = '0; bus.irq_ack = 1'b0; rst_n = 1'b0;

        step(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("rst_pend_vec", 32'(pend_vec), 32'h0);
        chk("rst_mask_q", 32'(bus.mask_q), 32'hf);
        chk("rst_valid", 32'(bus.irq_valid), 32'h0);
        chk("rst_id", 32'(bus.irq_id), 32'h0);

        // 1: single request, present and clear
        step(4'h0, 1'b1, 4'h0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 4'h0, 1'b0, 1'b1);
        wait_valid(4'b0100);
        chk("t1_id", 32'(bus.irq_id), 32'd2);
        chk("t1_pend_vec", 32'(pend_vec), 32'b0100);
        step(4'b0100, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("t1_valid_after_ack", 32'(bus.irq_valid), 32'd0);
        step(4'b0100, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("t1_pend_cleared", 32'(pend_vec), 32'h0);
        step(4'b0100, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("t1_stays_idle", 32'(bus.irq_valid), 32'd0);

        // 2: two simultaneous edges, priority order
        step(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b1001, 1'b0, 4'h0, 1'b0, 1'b1);
        wait_valid(4'b1001);
        chk("t2_first_id", 32'(bus.irq_id), 32'd3);
        step(4'b1001, 1'b0, 4'h0, 1'b1, 1'b1);
        wait_valid(4'b1001);
        chk("t2_second_id", 32'(bus.irq_id), 32'd0);
        step(4'b1001, 1'b0, 4'h0, 1'b1, 1'b1);

        // 3: masked source stays pending, appears on unmask
        step(4'h0, 1'b1, 4'b0010, 1'b0, 1'b1);
        step(4'b0010, 1'b0, 4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(4'b0010, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("t3_masked_pend_vec", 32'(pend_vec), 32'h0);
        chk("t3_masked_valid", 32'(bus.irq_valid), 32'd0);
        step(4'b0010, 1'b1, 4'h0, 1'b0, 1'b1);
        wait_valid(4'b0010);
        chk("t3_unmasked_id", 32'(bus.irq_id), 32'd1);
        step(4'b0010, 1'b0, 4'h0, 1'b1, 1'b1);

        // 4: presented ID frozen while a higher priority request arrives
        step(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b0001, 1'b0, 4'h0, 1'b0, 1'b1);
        wait_valid(4'b0001);
        chk("t4_id0", 32'(bus.irq_id), 32'd0);
        for (int k = 0; k < 5; k++) step(4'b1001, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("t4_id_frozen", 32'(bus.irq_id), 32'd0);
        step(4'b1001, 1'b0, 4'h0, 1'b1, 1'b1);
        wait_valid(4'b1001);
        chk("t4_next_id", 32'(bus.irq_id), 32'd3);
        step(4'b1001, 1'b0, 4'h0, 1'b1, 1'b1);

        // 5: new edge coinciding with ack of the same source
        step(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 4'h0, 1'b0, 1'b1);
        wait_valid(4'b0100);
        step(4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 4'h0, 1'b1, 1'b1);
        wait_valid(4'b0100);
        chk("t5_represent_id", 32'(bus.irq_id), 32'd2);

        // 6: reset while presenting
        step(4'b1100, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("t6_valid", 32'(bus.irq_valid), 32'd0);
        chk("t6_pend_vec", 32'(pend_vec), 32'h0);
        chk("t6_mask_q", 32'(bus.mask_q), 32'hf);

        // Randomized traffic
        step(4'h0, 1'b1, 4'h0, 1'b0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r_irq, r_din;
            logic r_we, r_ack, r_rst;
            r_irq = 4'($urandom);
            r_din = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            r_we  = ($urandom_range(0, 11) == 0);
            r_ack = 1'($urandom);
            r_rst = ($urandom_range(0, 119) != 0);
            step(r_irq, r_we, r_din, r_ack, r_rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
